// File: rtl/cbus_arbiter_if.sv
// Requester and cache-bus signal bundle for cbus_arbiter.
// The arbiter takes the master view because it drives the cache bus. The environment takes the slave view.
interface cbus_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_is_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb;
  logic [NUM_REQ-1:0]            resp_ready;
  logic [NUM_REQ-1:0]            resp_last;
  logic [DATA_WIDTH-1:0]         resp_data;

  logic                          creq_valid;
  logic                          creq_is_write;
  logic [ADDR_WIDTH-1:0]         creq_addr;
  logic [LEN_WIDTH-1:0]          creq_len;
  logic [DATA_WIDTH-1:0]         creq_data;
  logic [STRB_WIDTH-1:0]         creq_strb;
  logic                          cresp_ready;
  logic                          cresp_last;
  logic [DATA_WIDTH-1:0]         cresp_data;

  modport master (
    input  req_valid, req_is_write, req_addr, req_len, req_data, req_strb,
    input  cresp_ready, cresp_last, cresp_data,
    output resp_ready, resp_last, resp_data,
    output creq_valid, creq_is_write, creq_addr, creq_len, creq_data, creq_strb
  );

  modport slave (
    output req_valid, req_is_write, req_addr, req_len, req_data, req_strb,
    output cresp_ready, cresp_last, cresp_data,
    input  resp_ready, resp_last, resp_data,
    input  creq_valid, creq_is_write, creq_addr, creq_len, creq_data, creq_strb
  );
endinterface

// File: rtl/cbus_arbiter.sv
// Whole-transaction arbiter that shares one cache-bus port between NUM_REQ requesters (0 = D-side, 1 = I-side).
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin arbitration. Without it, the lowest requester index wins.
module cbus_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  cbus_arbiter_if.master     bus,
  output logic               busy,
  output logic [NUM_REQ-1:0] grant,
  output logic               len_err
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = LEN_WIDTH + 1;
  localparam int unsigned IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state, state_next;
  logic [NUM_REQ-1:0]   grant_next;
  logic [CNT_WIDTH-1:0] beat_cnt, beat_cnt_next;
  logic                 len_err_next;
  logic [IDX_WIDTH-1:0] g_idx, win_idx;
  logic                 win_found;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [LEN_WIDTH-1:0]  len_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [STRB_WIDTH-1:0] strb_arr [NUM_REQ];

  // Split the packed per-requester fields into indexable arrays
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[i]  = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
    assign data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign strb_arr[i] = bus.req_strb[i*STRB_WIDTH +: STRB_WIDTH];
  end

  // Index of the registered one-hot grant
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[IDX_WIDTH'(i)]) g_idx = IDX_WIDTH'(i);
    end
  end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_next, scan_idx;

  // The first valid requester after the last winner wins, with wrap-around
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: the lowest index wins, so D-side beats I-side
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[IDX_WIDTH'(k)]) begin
        win_idx   = IDX_WIDTH'(k);
        win_found = 1'b1;
      end
    end
  end
`endif

  // Next state, bus routing and response steering
  always_comb begin
    state_next     = state;
    grant_next     = grant;
    beat_cnt_next  = beat_cnt;
    len_err_next   = len_err;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    rr_ptr_next    = rr_ptr;
`endif
    bus.creq_valid    = 1'b0;
    bus.creq_is_write = 1'b0;
    bus.creq_addr     = '0;
    bus.creq_len      = '0;
    bus.creq_data     = '0;
    bus.creq_strb     = '0;
    bus.resp_ready    = '0;
    bus.resp_last     = '0;
    bus.resp_data     = '0;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_next          = BUSY;
          grant_next          = '0;
          grant_next[win_idx] = 1'b1;
          beat_cnt_next       = '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
          rr_ptr_next         = win_idx;
`endif
        end
      end
      BUSY: begin
        bus.creq_valid    = bus.req_valid[g_idx];
        bus.creq_is_write = bus.req_is_write[g_idx];
        bus.creq_addr     = addr_arr[g_idx];
        bus.creq_len      = len_arr[g_idx];
        bus.creq_data     = data_arr[g_idx];
        bus.creq_strb     = strb_arr[g_idx];
        bus.resp_data     = bus.cresp_data;
        if (bus.cresp_ready) begin
          bus.resp_ready = grant;
          if (beat_cnt != '1) beat_cnt_next = beat_cnt + CNT_WIDTH'(1);
          // beat_cnt holds the beats before this one, so a correct burst ends with beat_cnt == len
          if (bus.cresp_last) begin
            bus.resp_last = grant;
            if (beat_cnt != CNT_WIDTH'(len_arr[g_idx])) len_err_next = 1'b1;
            state_next = IDLE;
            grant_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      beat_cnt <= beat_cnt_next;
      len_err  <= len_err_next;
    end
  end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  // Starts at the last index so that requester 0 is scanned first after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= IDX_WIDTH'(NUM_REQ - 1);
    else       rr_ptr <= rr_ptr_next;
  end
`endif

  assign busy = (state == BUSY);

endmodule
